// File: rtl/opendap_swd_line_seq_gen_pkg.sv
// Shared SWD line-sequence constants, command encodings and FSM state type.
// Used by both the sequence generator and the alert LFSR.
package opendap_swd_line_seq_gen_pkg;

  localparam int unsigned CNT_W           = 7;
  localparam int unsigned LFSR_W          = 7;
  localparam int unsigned RESET_LEN       = 50;
  localparam int unsigned PRE_HIGH_LEN    = 8;
  localparam int unsigned ALERT_START_LEN = 1;
  localparam int unsigned ALERT_LEN       = 127;
  localparam int unsigned POST_ALERT_LEN  = 4;
  localparam int unsigned ACT_LEN         = 8;
  localparam int unsigned RST_IDLE_LEN    = 2;
  localparam int unsigned S2D_SEL_LEN     = 16;

  localparam logic [ACT_LEN-1:0]     SELECT_D2S = 8'b0101_1000;
  localparam logic [S2D_SEL_LEN-1:0] SELECT_S2D = 16'b0011_1101_1100_0111;
  localparam logic [LFSR_W-1:0]      LFSR_INIT  = 7'b100_1001;
  localparam logic [LFSR_W-1:0]      LFSR_TAPS  = 7'b100_1011;

  typedef enum logic [1:0] {
    CMD_LINE_RESET = 2'd0,
    CMD_D2S        = 2'd1,
    CMD_S2D        = 2'd2,
    CMD_NOP        = 2'd3
  } cmd_t;

  typedef enum logic [3:0] {
    IDLE,
    PRE_HIGH,
    ALERT_START,
    ALERT,
    POST_ALERT,
    ACT,
    RST_HIGH,
    RST_IDLE,
    S2D_SEL
  } state_t;

  // Down-counter load value for a phase of len bits (counts len-1 .. 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/opendap_swd_alert_lfsr.sv
// Selection-alert pseudo-random bit source; bit_out is the current LFSR LSB.
// load restarts the sequence, step advances it by one bit.
module opendap_swd_alert_lfsr
  import opendap_swd_line_seq_gen_pkg::*;
(
  input  logic swclk,
  input  logic rst,
  input  logic load,
  input  logic step,
  output logic bit_out
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge swclk) begin
    if (rst || load) begin
      r_lfsr <= LFSR_INIT;
    end else if (step) begin
      r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[LFSR_W-1:1]};
    end
  end

  assign bit_out = r_lfsr[0];

endmodule

// File: rtl/opendap_swd_line_seq_gen.sv
// SWD host line-sequence generator: line reset, dormant-to-SWD and SWD-to-dormant.
// Outputs are registered from the next state so the first bit appears on the accept edge.
module opendap_swd_line_seq_gen
  import opendap_swd_line_seq_gen_pkg::*;
(
  input  logic       swclk,
  input  logic       rst,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       swdo,
  output logic       swdo_oe,
  output logic       busy,
  output logic       done,
  output logic       dormant
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  cmd_t             r_cmd;
  logic             r_swdo;
  logic             r_oe;
  logic             r_done;
  logic             r_busy;
  logic             r_cmd_ready;
  logic             r_dormant;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_nop_done;
  logic             w_seq_done;
  logic             w_swdo_nxt;
  logic             w_lfsr_load;
  logic             w_lfsr_step;
  logic             w_lfsr_bit;

  assign w_accept = cmd_valid && r_cmd_ready;

  opendap_swd_alert_lfsr u_alert_lfsr (
    .swclk   (swclk),
    .rst     (rst),
    .load    (w_lfsr_load),
    .step    (w_lfsr_step),
    .bit_out (w_lfsr_bit)
  );

  // State register plus registered line outputs and link-state tracking.
  always_ff @(posedge swclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd       <= CMD_NOP;
      r_swdo      <= 1'b0;
      r_oe        <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_dormant   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_swdo      <= w_swdo_nxt;
      r_oe        <= (w_state_nxt != IDLE);
      r_done      <= w_nop_done || w_seq_done;
      r_busy      <= (w_state_nxt != IDLE);
      r_cmd_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_cmd <= cmd_t'(cmd);
      end
      if (w_seq_done) begin
        if (r_cmd == CMD_S2D) begin
          r_dormant <= 1'b1;
        end else if (r_cmd == CMD_D2S) begin
          r_dormant <= 1'b0;
        end
      end
    end
  end

  // Next state / counter, then the line value for the bit about to be presented.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_nop_done  = 1'b0;
    w_seq_done  = 1'b0;
    w_swdo_nxt  = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;

    if (r_state == IDLE) begin
      if (w_accept) begin
        case (cmd_t'(cmd))
          CMD_LINE_RESET, CMD_S2D: begin
            w_state_nxt = RST_HIGH;
            w_cnt_nxt   = cnt_load(RESET_LEN);
          end
          CMD_D2S: begin
            w_state_nxt = PRE_HIGH;
            w_cnt_nxt   = cnt_load(PRE_HIGH_LEN);
          end
          default: begin
            w_nop_done = 1'b1;
          end
        endcase
      end
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      case (r_state)
        PRE_HIGH: begin
          w_state_nxt = ALERT_START;
          w_cnt_nxt   = cnt_load(ALERT_START_LEN);
        end
        ALERT_START: begin
          w_state_nxt = ALERT;
          w_cnt_nxt   = cnt_load(ALERT_LEN);
        end
        ALERT: begin
          w_state_nxt = POST_ALERT;
          w_cnt_nxt   = cnt_load(POST_ALERT_LEN);
        end
        POST_ALERT: begin
          w_state_nxt = ACT;
          w_cnt_nxt   = cnt_load(ACT_LEN);
        end
        ACT: begin
          w_state_nxt = RST_HIGH;
          w_cnt_nxt   = cnt_load(RESET_LEN);
        end
        RST_HIGH: begin
          if (r_cmd == CMD_S2D) begin
            w_state_nxt = S2D_SEL;
            w_cnt_nxt   = cnt_load(S2D_SEL_LEN);
          end else begin
            w_state_nxt = RST_IDLE;
            w_cnt_nxt   = cnt_load(RST_IDLE_LEN);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // LFSR holds the alert bit to present; reload as the start zero goes out.
    w_lfsr_load = (w_state_nxt == ALERT_START);
    w_lfsr_step = (w_state_nxt == ALERT);

    case (w_state_nxt)
      PRE_HIGH, RST_HIGH: w_swdo_nxt = 1'b1;
      ALERT:              w_swdo_nxt = w_lfsr_bit;
      ACT:                w_swdo_nxt = SELECT_D2S[w_cnt_nxt[2:0]];
      S2D_SEL:            w_swdo_nxt = SELECT_S2D[w_cnt_nxt[3:0]];
      default:            w_swdo_nxt = 1'b0;
    endcase

    w_seq_done = ((w_state_nxt == RST_IDLE) || (w_state_nxt == S2D_SEL)) &&
                 (w_cnt_nxt == '0);
  end

  assign cmd_ready = r_cmd_ready;
  assign swdo      = r_swdo;
  assign swdo_oe   = r_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dormant   = r_dormant;

endmodule

// File: tb/tb_opendap_swd_line_seq_gen.sv
// Directed self-checking bench for the SWD line-sequence generator.
module tb_opendap_swd_line_seq_gen;

  logic       swclk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       swdo;
  logic       swdo_oe;
  logic       busy;
  logic       done;
  logic       dormant;

  int n_total = 0;
  int n_bad   = 0;

  logic bits     [0:255];
  logic exp_bits [0:255];
  int   cap_n, cap_first, cap_done_idx, cap_done_cnt, cap_hs_err, exp_n;

  logic [65:0] mon_sr    = '0;
  logic [65:0] enter_pat = {{50{1'b1}}, 16'b0011_1101_1100_0111};
  logic [63:0] exit_pat  = {4'b0000, 8'b0101_1000, {50{1'b1}}, 2'b00};
  int          enter_cnt = 0;
  int          exit_cnt  = 0;
  time         enter_t   = 0;
  time         exit_t    = 0;

  always #5 swclk = ~swclk;

  opendap_swd_line_seq_gen dut (
    .swclk     (swclk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .swdo      (swdo),
    .swdo_oe   (swdo_oe),
    .busy      (busy),
    .done      (done),
    .dormant   (dormant)
  );

  // Dormant-state monitor on the driven line bits.
  always @(negedge swclk) begin
    if (swdo_oe) begin
      mon_sr <= {mon_sr[64:0], swdo};
      if ({mon_sr[64:0], swdo} == enter_pat) begin
        enter_cnt <= enter_cnt + 1;
        enter_t   <= $time;
      end
      if ({mon_sr[62:0], swdo} == exit_pat) begin
        exit_cnt <= exit_cnt + 1;
        exit_t   <= $time;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] c);
    @(negedge swclk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(posedge swclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic capture(input int max_cyc);
    bit ended = 1'b0;
    cap_n = 0; cap_first = -1; cap_done_idx = -1; cap_done_cnt = 0; cap_hs_err = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge swclk);
      if (swdo_oe) begin
        if (cap_first < 0) cap_first = c;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) cap_hs_err++;
        if (cap_n < 256) bits[cap_n] = swdo;
        if (done) begin
          cap_done_idx = cap_n;
          cap_done_cnt++;
        end
        cap_n++;
      end else if (cap_n > 0) begin
        ended = 1'b1;
        chk("idle_swdo", int'(swdo), 0);
        chk("idle_ready", int'(cmd_ready), 1);
        break;
      end
    end
    chk("seq_end_in_budget", int'(ended), 1);
  endtask

  task automatic build_exp(input logic [1:0] c);
    logic [6:0]  l   = 7'b100_1001;
    logic [7:0]  act = 8'b0101_1000;
    logic [15:0] sel = 16'b0011_1101_1100_0111;
    exp_n = 0;
    if (c == 2'd1) begin
      for (int i = 0; i < 8; i++) exp_bits[exp_n++] = 1'b1;
      exp_bits[exp_n++] = 1'b0;
      for (int i = 0; i < 127; i++) begin
        exp_bits[exp_n++] = l[0];
        l = {^(l & 7'b100_1011), l[6:1]};
      end
      for (int i = 0; i < 4; i++) exp_bits[exp_n++] = 1'b0;
      for (int i = 7; i >= 0; i--) exp_bits[exp_n++] = act[i];
    end
    for (int i = 0; i < 50; i++) exp_bits[exp_n++] = 1'b1;
    if (c == 2'd2) begin
      for (int i = 15; i >= 0; i--) exp_bits[exp_n++] = sel[i];
    end else begin
      exp_bits[exp_n++] = 1'b0;
      exp_bits[exp_n++] = 1'b0;
    end
  endtask

  task automatic cmp_seq(input string tag);
    int nerr = 0;
    for (int i = 0; i < exp_n && i < cap_n; i++)
      if (bits[i] !== exp_bits[i]) nerr++;
    chk({tag, "_len"}, cap_n, exp_n);
    chk({tag, "_bit_errs"}, nerr, 0);
    chk({tag, "_done_at"}, cap_done_idx, exp_n - 1);
    chk({tag, "_done_cnt"}, cap_done_cnt, 1);
    chk({tag, "_latency"}, cap_first, 1);
    chk({tag, "_busy_ready"}, cap_hs_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] head;
    logic [7:0]  act;
    int          ones;
    int          dn;

    rst = 1'b1; cmd = 2'd0; cmd_valid = 1'b0;
    repeat (2) @(posedge swclk);
    @(negedge swclk);
    chk("rst_swdo", int'(swdo), 0);
    chk("rst_oe", int'(swdo_oe), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_dormant", int'(dormant), 0);
    rst = 1'b0;

    // Plain line reset while the link is active.
    send(2'd0); capture(100);
    build_exp(2'd0); cmp_seq("lr0");
    chk("lr0_dormant", int'(dormant), 0);

    // Enter dormant.
    send(2'd2); capture(120);
    build_exp(2'd2); cmp_seq("s2d");
    chk("s2d_dormant", int'(dormant), 1);
    chk("mon_enter_after_s2d", enter_cnt, 1);
    chk("mon_exit_after_s2d", exit_cnt, 0);

    // Line reset and NOP leave the dormant flag alone.
    send(2'd0); capture(100);
    build_exp(2'd0); cmp_seq("lr1");
    chk("lr1_dormant", int'(dormant), 1);

    send(2'd3);
    @(negedge swclk);
    chk("nop_done", int'(done), 1);
    chk("nop_oe", int'(swdo_oe), 0);
    @(negedge swclk);
    chk("nop_done_clr", int'(done), 0);
    chk("nop_oe_after", int'(swdo_oe), 0);
    chk("nop_dormant", int'(dormant), 1);

    // Exit dormant.
    send(2'd1); capture(260);
    build_exp(2'd1); cmp_seq("d2s");
    head = '0;
    for (int i = 0; i < 16; i++) head = {head[14:0], bits[i]};
    chk("d2s_head", int'(head), 16'hFF49);
    ones = 0;
    for (int i = 136; i < 140; i++) ones += int'(bits[i]);
    chk("d2s_post_zeros", ones, 0);
    act = '0;
    for (int i = 140; i < 148; i++) act = {act[6:0], bits[i]};
    chk("d2s_act", int'(act), 8'b0101_1000);
    chk("d2s_dormant", int'(dormant), 0);
    chk("mon_enter_total", enter_cnt, 1);
    chk("mon_exit_total", exit_cnt, 1);
    chk("mon_order", int'(enter_t < exit_t), 1);

    // Abort a D2S part-way with reset.
    send(2'd1);
    dn = 0;
    repeat (70) begin
      @(negedge swclk);
      dn += int'(done);
    end
    rst = 1'b1;
    @(posedge swclk);
    @(negedge swclk);
    rst = 1'b0;
    chk("abort_done_during", dn, 0);
    chk("abort_oe", int'(swdo_oe), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    send(2'd0); capture(100);
    build_exp(2'd0); cmp_seq("lr_after_abort");

    // cmd_valid held with cmd changing while busy: only the first command runs.
    @(negedge swclk);
    cmd = 2'd0; cmd_valid = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge swclk);
          cmd = 2'(i % 3 + 1);
        end
        cmd_valid = 1'b0;
      end
      capture(100);
    join
    build_exp(2'd0); cmp_seq("hold");
    chk("hold_dormant", int'(dormant), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
